cache_mem_arbiter: RTL
======================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares the single cacheline adaptor / memory port between the I-cache (read-only) and the D-cache (read/write).
//  Sits between the two L1 caches and the cacheline adaptor.
//  Serialises whole 256-bit line transactions and latches the winner's address and write data.
//  Inserts one turnaround cycle after every transaction so the adaptor sees strobes low when it re-enters idle.
// PARAMETERS
//  LINE_W  256  cacheline width in bits
//  ADDR_W  32   address width in bits
//  PRIO_D  0    0 = round-robin on ties; 1 = fixed priority, D-cache always wins ties
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, synchronous, active-high
//  i_address    in   ADDR_W  I-cache line address
//  i_read       in   1       I-cache line read request
//  i_rdata      out  LINE_W  line returned to I-cache
//  i_resp       out  1       I-cache transaction done (1-cycle pulse)
//  d_address    in   ADDR_W  D-cache line address
//  d_read       in   1       D-cache line read request
//  d_write      in   1       D-cache line write-back request
//  d_wdata      in   LINE_W  D-cache write-back line
//  d_rdata      out  LINE_W  line returned to D-cache
//  d_resp       out  1       D-cache transaction done (1-cycle pulse)
//  mem_address  out  ADDR_W  to adaptor address_i
//  mem_read     out  1       to adaptor read_i
//  mem_write    out  1       to adaptor write_i
//  mem_wdata    out  LINE_W  to adaptor line_i
//  mem_rdata    in   LINE_W  from adaptor line_o
//  mem_resp     in   1       from adaptor resp_o
// BEHAVIOUR
//  - Reset: state=IDLE, last_grant=I, addr/wdata latches=0; mem_read, mem_write, i_resp, d_resp = 0.
//  - States:
//    - IDLE: no request -> stay. Otherwise pick winner; latch address (and d_wdata, op); -> SERVE_I or SERVE_D.
//    - SERVE_x: drive mem_read/mem_write from the latched op. On mem_resp: pulse x_resp the same cycle, combinationally, and update last_grant=x; -> RECOVER.
//    - RECOVER: mem_read=mem_write=0 for exactly one cycle; no grant decision is made; -> IDLE.
//  - Tie-break in IDLE:
//    - PRIO_D=1: D wins.
//    - PRIO_D=0: the requester other than last_grant wins. First tie after reset goes to D.
//  - Latency: a request seen in IDLE at cycle N drives mem strobe at N+1. Minimum gap between two transactions: RECOVER + IDLE = 2 cycles.
//  - Requesters hold read/write high until their resp.
//  - Once granted, the requester's inputs are ignored: address and wdata come from the latches.
//  - A request dropped before grant is simply not served.
//  - d_read && d_write together: treat as write. Simulation assertion flags it.
//  - i_rdata = d_rdata = mem_rdata at all times (broadcast); only x_resp qualifies the data.
//  - Never both i_resp and d_resp in one cycle. Never mem_read && mem_write.
//  - mem_resp outside SERVE_x: ignored; no resp generated.
//  - rst mid-transaction: next cycle IDLE with all strobes 0 and no resp. The adaptor is reset on the same rst.
// STRUCTURE
//  - cache_arb_pkg:
//    - arb_state_t {IDLE, SERVE_I, SERVE_D, RECOVER}
//    - grant_t {GRANT_I, GRANT_D}
//    - LINE_W / ADDR_W localparams
//  - Sub-module arb2_pick: combinational 2-way picker (req_i, req_d, last_grant, PRIO_D -> grant_t).
//  - Top holds the FSM, latches and output muxing.
// TESTING
//  1. i_read @0x0000_1040 alone:
//     - mem_read=1 and mem_address=0x1040 next cycle.
//     - mem_resp with rdata=0xA5..A5 -> i_resp 1 cycle, i_rdata=0xA5..A5, d_resp=0.
//     - Strobes 0 in the following cycle.
//  2. PRIO_D=0, after reset i_read @0x100 and d_write @0x200 (wdata=0x1234..) in the same cycle:
//     - D served first: mem_write=1, mem_wdata=0x1234...
//     - d_resp, then RECOVER, IDLE, then mem_read @0x100, then i_resp.
//  3. PRIO_D=0, both requesters re-request immediately after each resp for 4 transactions -> grant order D,I,D,I.
//  4. PRIO_D=1, D issues back-to-back reads while i_read is held -> I served only once D leaves a cycle with no request.
//  5. d_address changes from 0x300 to 0x340 while in SERVE_D -> mem_address stays 0x300 until mem_resp.
//  6. rst pulsed while in SERVE_D -> next cycle mem_read=mem_write=0, no d_resp, state IDLE; a fresh request then completes normally.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and widths for the I/D-cache to memory-port arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which requester owns (or last owned) the memory port
package cache_arb_pkg;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RECOVER
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and cacheline-adaptor signals around the arbiter.
//   master : arbiter view (consumes cache requests and adaptor data, drives the memory port)
//   slave  : environment view (caches and adaptor), the mirror image of master
interface cache_mem_arbiter_if;
  import cache_arb_pkg::*;

  // I-cache side
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  // D-cache side
  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  // Cacheline adaptor side
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    input  i_address, i_read, d_address, d_read, d_write, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_address, mem_read, mem_write, mem_wdata
  );

  modport slave (
    output i_address, i_read, d_address, d_read, d_write, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_address, mem_read, mem_write, mem_wdata
  );

endinterface

// File: rtl/arb2_pick.sv
// Combinational two-way picker between the I-cache and D-cache requests.
//   req_i_i      : I-cache is requesting
//   req_d_i      : D-cache is requesting
//   last_grant_i : requester served most recently
//   grant_o      : winner (only meaningful when at least one request is high)
module arb2_pick
  import cache_arb_pkg::*;
#(
  parameter bit PRIO_D = 1'b0
) (
  input  logic   req_i_i,
  input  logic   req_d_i,
  input  grant_t last_grant_i,
  output grant_t grant_o
);

  always_comb begin
    grant_o = GRANT_I;
    // D wins when alone, or on a tie under fixed priority, or on a round-robin tie after I
    if (req_d_i && (!req_i_i || PRIO_D || (last_grant_i == GRANT_I))) begin
      grant_o = GRANT_D;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single cacheline adaptor between the I-cache (read-only) and D-cache (read/write).
// Whole-line transactions are serialised; the winner's address, write data and operation are
// latched at grant, and one idle turnaround cycle follows every transaction.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : cache and adaptor signals (master modport)
// PRIO_D = 0 selects round-robin on ties, 1 lets the D-cache always win ties.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter bit PRIO_D = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  cache_mem_arbiter_if.master bus
);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;

  logic   i_req, d_req;
  grant_t pick;
  logic   mem_read, mem_write, i_resp, d_resp;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  arb2_pick #(
    .PRIO_D (PRIO_D)
  ) u_pick (
    .req_i_i      (i_req),
    .req_d_i      (d_req),
    .last_grant_i (last_grant_q),
    .grant_o      (pick)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (pick == GRANT_D) begin
            addr_d  = bus.d_address;
            wdata_d = bus.d_wdata;
            wr_d    = bus.d_write; // read+write together is served as a write
            state_d = SERVE_D;
          end else begin
            addr_d  = bus.i_address;
            wr_d    = 1'b0;
            state_d = SERVE_I;
          end
        end
      end
      SERVE_I: begin
        mem_read = 1'b1;
        if (bus.mem_resp) begin
          i_resp       = 1'b1;
          last_grant_d = GRANT_I;
          state_d      = RECOVER;
        end
      end
      SERVE_D: begin
        mem_read  = ~wr_q;
        mem_write = wr_q;
        if (bus.mem_resp) begin
          d_resp       = 1'b1;
          last_grant_d = GRANT_D;
          state_d      = RECOVER;
        end
      end
      RECOVER: begin
        // strobes stay low so the adaptor re-enters idle before the next grant
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
    end
  end

  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.i_resp      = i_resp;
  assign bus.d_resp      = d_resp;
  // read data is broadcast; only the resp pulse qualifies it
  assign bus.i_rdata     = bus.mem_rdata;
  assign bus.d_rdata     = bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.d_read && bus.d_write))
        else $warning("d_read and d_write both high, served as a write");
      assert (!(mem_read && mem_write)) else $error("mem_read and mem_write both high");
      assert (!(i_resp && d_resp)) else $error("i_resp and d_resp both high");
    end
  end

endmodule
